edge_event_counter: RTL

Downstream stage for a raw single-bit flip-flop output: takes an asynchronous level `d`, synchronizes it, debounces it, detects rising/falling edges and counts selected edges. Feeds status/interrupt logic with a clean level, single-cycle edge pulses and an event count with sticky overflow.

---
 rtl/edge_event_pkg.sv | 28 ++
 rtl/sync2.sv | 28 ++
 rtl/edge_event_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/edge_event_pkg.sv
// Shared types and constants for the edge event counter.
//   state_e       : debounce FSM states
//   MODE_*        : count select encodings for the mode input
//   counts_rise() : true when the mode counts accepted rising edges
//   counts_fall() : true when the mode counts accepted falling edges
package edge_event_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      PEND_HI   = 2'b01,
      STABLE_HI = 2'b10,
      PEND_LO   = 2'b11
   } state_e;

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;
   localparam logic [1:0] MODE_NONE = 2'b11;

   function automatic logic counts_rise(input logic [1:0] mode);
      return (mode == MODE_RISE) || (mode == MODE_BOTH);
   endfunction

   function automatic logic counts_fall(input logic [1:0] mode);
      return (mode == MODE_FALL) || (mode == MODE_BOTH);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/edge_event_counter.sv
// Synchronizes and debounces an asynchronous level, emits one-cycle edge
// pulses for accepted transitions and counts the edges selected by mode.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   d     : raw asynchronous input level
//   mode  : 00 count rise, 01 count fall, 10 count both, 11 count none
//   clr   : synchronous clear of count and ovf (wins over a same-cycle event)
//   q     : debounced level
//   rise  : one-cycle pulse after an accepted 0->1
//   fall  : one-cycle pulse after an accepted 1->0
//   count : wrapping count of selected edges
//   ovf   : sticky flag, set when count wraps
module edge_event_counter
   import edge_event_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int unsigned     SC_W    = $clog2(STABLE_CYCLES);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);

   logic d_s;

   state_e           state_q, state_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic             q_q, q_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             event_hit;

   sync2 u_sync2 (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (d_s)
   );

   // The sample that leaves STABLE_* already counts as the first of the
   // run, so a PEND state accepts once sc reaches STABLE_CYCLES-1.
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (d_s) begin
               state_d = PEND_HI;
               sc_d    = SC_W'(1);
            end
         end
         PEND_HI: begin
            if (!d_s) begin
               state_d = STABLE_LO;
               sc_d    = '0;
            end else if (sc_q == SC_LAST) begin
               state_d = STABLE_HI;
               sc_d    = '0;
               q_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               sc_d = sc_q + SC_W'(1);
            end
         end
         STABLE_HI: begin
            if (!d_s) begin
               state_d = PEND_LO;
               sc_d    = SC_W'(1);
            end
         end
         PEND_LO: begin
            if (d_s) begin
               state_d = STABLE_HI;
               sc_d    = '0;
            end else if (sc_q == SC_LAST) begin
               state_d = STABLE_LO;
               sc_d    = '0;
               q_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               sc_d = sc_q + SC_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            sc_d    = '0;
         end
      endcase
   end

   // Events are taken from the pulse being decided on this edge, so the
   // count moves together with rise/fall and uses this cycle's mode.
   always_comb begin
      event_hit = (rise_d && counts_rise(mode)) || (fall_d && counts_fall(mode));
      count_d   = count_q;
      ovf_d     = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (event_hit) begin
         count_d = count_q + CNT_W'(1);
         if (&count_q) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= STABLE_LO;
         sc_q    <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q     = q_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign count = count_q;
   assign ovf   = ovf_q;

endmodule
